// File: rtl/qeciphy_pkg.sv
// Shared state and error-code encodings for the QECi PHY lane controller.
package qeciphy_pkg;

  typedef enum logic [3:0] {
    ST_RESET              = 4'd0,
    ST_WAIT_FOR_RESET     = 4'd1,
    ST_LINK_TRAINING      = 4'd2,
    ST_RX_LOCKED          = 4'd3,
    ST_LINK_READY         = 4'd4,
    ST_FAULT_FATAL        = 4'd5,
    ST_SLEEP              = 4'd6,
    ST_WAIT_FOR_POWERDOWN = 4'd7,
    ST_RETRY              = 4'd8
  } fsm_t;

  typedef enum logic [3:0] {
    EC_OK              = 4'd0,
    EC_FAP_MISSING     = 4'd1,
    EC_CRC_ERROR       = 4'd2,
    EC_CRC_LIMIT       = 4'd3,
    EC_TRAIN_TIMEOUT   = 4'd4,
    EC_RETRY_EXHAUSTED = 4'd5
  } error_t;

endpackage

// File: rtl/qeciphy_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module qeciphy_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/qeciphy_lane_controller.sv
// Link bring-up, retry, error reporting and powerdown handshake for a
// multi-lane QECi PHY receiver.
module qeciphy_lane_controller
  import qeciphy_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned TRAIN_TIMEOUT = 65535,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CRC_ERR_LIMIT = 8,
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic                 i_reset_done,
  input  logic [NUM_LANES-1:0] i_rx_rdy,
  input  logic                 i_remote_rx_rdy,
  input  logic [NUM_LANES-1:0] i_fap_missing,
  input  logic [NUM_LANES-1:0] i_crc_error,
  input  logic                 i_preq,
  input  logic                 i_pstate,
  output logic                 o_paccept,
  input  logic                 i_remote_pd_req,
  input  logic                 i_remote_pd_ack,
  output logic                 o_pd_req,
  output logic                 o_pd_ack,
  output logic [3:0]           o_state,
  output logic [3:0]           o_ecode,
  output logic [RW-1:0]        o_retry_cnt,
  output logic [7:0]           o_crc_err_cnt,
  output logic                 o_rst_n
);

  localparam int unsigned TW = (TRAIN_TIMEOUT > 1) ? $clog2(TRAIN_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TRAIN_TIMEOUT - 1);
  localparam logic [7:0]    CRC_LAST = 8'(CRC_ERR_LIMIT - 1);
  localparam logic [7:0]    CRC_LIM  = 8'(CRC_ERR_LIMIT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  fsm_t          state_q;
  error_t        ecode_q;
  logic [RW-1:0] retry_q;
  logic          pd_req_q, pu_req_q, paccept_q, rst_n_q;

  logic          any_fap, any_crc, all_rdy;
  logic          in_train, in_link, train_start;
  logic [TW-1:0] timer;
  logic [7:0]    crc_cnt;

  assign any_fap     = |i_fap_missing;
  assign any_crc     = |i_crc_error;
  assign all_rdy     = &i_rx_rdy;
  assign in_train    = (state_q == ST_LINK_TRAINING) || (state_q == ST_RX_LOCKED);
  assign in_link     = (state_q == ST_RX_LOCKED) || (state_q == ST_LINK_READY);
  assign train_start = (state_q == ST_WAIT_FOR_RESET) && i_reset_done;

  // Held at zero outside training, so it reads zero on LINK_TRAINING entry
  // and keeps running across the RX_LOCKED transition.
  qeciphy_sat_counter #(.WIDTH(TW)) u_train_timer (
    .clk_i (axis_clk),
    .rst_i (axis_rst),
    .clr_i (!in_train),
    .en_i  (in_train),
    .cnt_o (timer)
  );

  qeciphy_sat_counter #(.WIDTH(8)) u_crc_cnt (
    .clk_i (axis_clk),
    .rst_i (axis_rst),
    .clr_i (train_start),
    .en_i  (in_link && any_crc),
    .cnt_o (crc_cnt)
  );

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q   <= ST_RESET;
      ecode_q   <= EC_OK;
      retry_q   <= '0;
      pd_req_q  <= 1'b0;
      pu_req_q  <= 1'b0;
      paccept_q <= 1'b0;
      rst_n_q   <= 1'b0;
    end else begin
      rst_n_q  <= !(state_q inside {ST_RESET, ST_RETRY, ST_SLEEP, ST_FAULT_FATAL});
      pu_req_q <= (state_q == ST_SLEEP) && i_preq && i_pstate;

      if (!i_preq && paccept_q)
        paccept_q <= 1'b0;
      else if (((state_q == ST_SLEEP) && i_preq && !i_pstate) ||
               ((state_q == ST_LINK_READY) && i_preq && i_pstate))
        paccept_q <= 1'b1;

      if ((state_q == ST_LINK_READY) && i_preq && !i_pstate)
        pd_req_q <= 1'b1;
      else if (state_q == ST_SLEEP)
        pd_req_q <= 1'b0;

      if (pu_req_q)
        retry_q <= '0;

      // A retry cause assigned in the case below overrides this update.
      if (in_link && any_crc && (crc_cnt < CRC_LIM))
        ecode_q <= EC_CRC_ERROR;

      case (state_q)
        ST_RESET:          state_q <= ST_WAIT_FOR_RESET;
        ST_WAIT_FOR_RESET: if (i_reset_done) state_q <= ST_LINK_TRAINING;
        ST_LINK_TRAINING: begin
          if (all_rdy)
            state_q <= ST_RX_LOCKED;
          else if (timer == TMO_LAST) begin
            state_q <= ST_RETRY;
            ecode_q <= EC_TRAIN_TIMEOUT;
          end
        end
        ST_RX_LOCKED: begin
          if (any_fap) begin
            state_q <= ST_RETRY;
            ecode_q <= EC_FAP_MISSING;
          end else if (timer == TMO_LAST) begin
            state_q <= ST_RETRY;
            ecode_q <= EC_TRAIN_TIMEOUT;
          end else if (i_remote_rx_rdy)
            state_q <= ST_LINK_READY;
        end
        ST_LINK_READY: begin
          if (any_fap) begin
            state_q <= ST_RETRY;
            ecode_q <= EC_FAP_MISSING;
          end else if (any_crc && (crc_cnt == CRC_LAST)) begin
            state_q <= ST_RETRY;
            ecode_q <= EC_CRC_LIMIT;
          end else if (i_remote_pd_ack)
            state_q <= ST_SLEEP;
          else if (i_remote_pd_req)
            state_q <= ST_WAIT_FOR_POWERDOWN;
        end
        ST_RETRY: begin
          if (retry_q == RETRY_MAX) begin
            state_q <= ST_FAULT_FATAL;
            ecode_q <= EC_RETRY_EXHAUSTED;
          end else begin
            retry_q <= retry_q + RW'(1);
            state_q <= ST_RESET;
          end
        end
        ST_SLEEP:              if (pu_req_q) state_q <= ST_WAIT_FOR_RESET;
        ST_WAIT_FOR_POWERDOWN: if (any_fap) state_q <= ST_RESET;
        ST_FAULT_FATAL:        state_q <= ST_FAULT_FATAL;
        default:               state_q <= ST_RESET;
      endcase
    end
  end

  assign o_state       = state_q;
  assign o_ecode       = ecode_q;
  assign o_retry_cnt   = retry_q;
  assign o_crc_err_cnt = crc_cnt;
  assign o_pd_req      = pd_req_q;
  assign o_pd_ack      = i_remote_pd_req;
  assign o_paccept     = paccept_q;
  assign o_rst_n       = rst_n_q;

endmodule

// File: tb/tb_qeciphy_lane_controller.sv
// Bench for qeciphy_lane_controller: vector table, directed corner sequences
// and randomized stimulus against a behavioural model.
module tb_qeciphy_lane_controller;

  localparam int NL  = 4;
  localparam int TT  = 16;
  localparam int MR  = 1;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reset_done, remote_rx_rdy, preq, pstate, rpd_req, rpd_ack;
  logic [NL-1:0] rx_rdy, fap, crc;
  logic          paccept, pd_req, pd_ack, rst_n;
  logic [3:0]    state, ecode;
  logic [0:0]    retry_cnt;
  logic [7:0]    crc_cnt;

  qeciphy_lane_controller #(
    .NUM_LANES(NL), .TRAIN_TIMEOUT(TT), .MAX_RETRIES(MR), .CRC_ERR_LIMIT(LIM)
  ) dut (
    .axis_clk(clk), .axis_rst(rst), .i_reset_done(reset_done), .i_rx_rdy(rx_rdy),
    .i_remote_rx_rdy(remote_rx_rdy), .i_fap_missing(fap), .i_crc_error(crc),
    .i_preq(preq), .i_pstate(pstate), .o_paccept(paccept),
    .i_remote_pd_req(rpd_req), .i_remote_pd_ack(rpd_ack),
    .o_pd_req(pd_req), .o_pd_ack(pd_ack), .o_state(state), .o_ecode(ecode),
    .o_retry_cnt(retry_cnt), .o_crc_err_cnt(crc_cnt), .o_rst_n(rst_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rdone; logic [NL-1:0] rdy; logic rrdy; logic [NL-1:0] fap;
    logic [NL-1:0] crc; logic preq; logic pstate; logic rpdreq; logic rpdack;
  } in_t;

  typedef struct { in_t in; int st, ec, rc, cc; bit pdreq, rstn; } vec_t;
  typedef struct { int st, ec, rc, cc, tm; bit pdreq, pureq, pacc, rstn; } mdl_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(in_t x);
    reset_done = x.rdone; rx_rdy = x.rdy; remote_rx_rdy = x.rrdy; fap = x.fap;
    crc = x.crc; preq = x.preq; pstate = x.pstate; rpd_req = x.rpdreq; rpd_ack = x.rpdack;
  endtask

  task automatic add(bit rdone, logic [NL-1:0] rdy, bit rrdy, logic [NL-1:0] c,
                     bit pq, bit ps, bit pack, int st, int ec, int cc, bit pdr, bit rn);
    vec_t v;
    v.in = '0;
    v.in.rdone = rdone; v.in.rdy = rdy; v.in.rrdy = rrdy; v.in.crc = c;
    v.in.preq = pq; v.in.pstate = ps; v.in.rpdack = pack;
    v.st = st; v.ec = ec; v.rc = 0; v.cc = cc; v.pdreq = pdr; v.rstn = rn;
    tbl.push_back(v);
  endtask

  task automatic reset_dut();
    drive('0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", state, 0);   check("rst_ecode", ecode, 0);
    check("rst_retry", retry_cnt, 0); check("rst_crc_cnt", crc_cnt, 0);
    check("rst_rst_n", rst_n, 0);   check("rst_pd_req", pd_req, 0);
    check("rst_paccept", paccept, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(int s, int budget, string name);
    int k = 0;
    while (state != 4'(s) && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check(name, state, s);
  endtask

  // Behavioural reference: one clock step of the controller per the rules.
  function automatic mdl_t model_next(mdl_t c, in_t x);
    mdl_t n = c;
    bit   a_fap = |x.fap;
    bit   a_crc = |x.crc;
    bit   a_rdy = &x.rdy;
    n.rstn  = !(c.st == 0 || c.st == 8 || c.st == 6 || c.st == 5);
    n.pureq = (c.st == 6) && x.preq && x.pstate;
    if (!x.preq && c.pacc) n.pacc = 0;
    else if ((c.st == 6 && x.preq && !x.pstate) || (c.st == 4 && x.preq && x.pstate)) n.pacc = 1;
    if (c.st == 4 && x.preq && !x.pstate) n.pdreq = 1;
    else if (c.st == 6) n.pdreq = 0;
    n.tm = (c.st == 2 || c.st == 3) ? c.tm + 1 : 0;
    if ((c.st == 3 || c.st == 4) && a_crc) begin
      n.cc = (c.cc >= 255) ? 255 : c.cc + 1;
      if (c.cc < LIM) n.ec = 2;
    end
    if (c.pureq) n.rc = 0;
    case (c.st)
      0: n.st = 1;
      1: if (x.rdone) begin n.st = 2; n.cc = 0; end
      2: if (a_rdy) n.st = 3;
         else if (c.tm == TT - 1) begin n.st = 8; n.ec = 4; end
      3: if (a_fap) begin n.st = 8; n.ec = 1; end
         else if (c.tm == TT - 1) begin n.st = 8; n.ec = 4; end
         else if (x.rrdy) n.st = 4;
      4: if (a_fap) begin n.st = 8; n.ec = 1; end
         else if (a_crc && c.cc == LIM - 1) begin n.st = 8; n.ec = 3; end
         else if (x.rpdack) n.st = 6;
         else if (x.rpdreq) n.st = 7;
      8: if (c.rc == MR) begin n.st = 5; n.ec = 5; end
         else begin n.rc = c.rc + 1; n.st = 0; end
      6: if (c.pureq) n.st = 1;
      7: if (a_fap) n.st = 0;
      default: ;
    endcase
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t x = '0;
    x.rdone  = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NL; i++) begin
      x.rdy[i] = ($urandom_range(0, 7) != 0);
      x.fap[i] = ($urandom_range(0, 127) == 0);
      x.crc[i] = ($urandom_range(0, 15) == 0);
    end
    x.rrdy   = $urandom_range(0, 1) == 1;
    x.preq   = $urandom_range(0, 1) == 1;
    x.pstate = $urandom_range(0, 1) == 1;
    x.rpdreq = ($urandom_range(0, 7) == 0);
    x.rpdack = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  x;
    mdl_t m;
    int   n;
    logic [23:0] act, exp;

    // rdone rdy rrdy crc preq pst pdack | st ec cc pdreq rst_n
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 4'b0001, 0, 4'b0000, 0, 0, 0,  2, 0, 0, 0, 1);
    add(1, 4'b0011, 0, 4'b0000, 0, 0, 0,  2, 0, 0, 0, 1);
    add(1, 4'b0111, 0, 4'b0000, 0, 0, 0,  2, 0, 0, 0, 1);
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0,  2, 0, 0, 0, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0, 0,  3, 0, 0, 0, 1);
    add(1, 4'b1111, 1, 4'b0001, 0, 0, 0,  4, 0, 0, 0, 1);
    add(1, 4'b1111, 1, 4'b0100, 0, 0, 0,  4, 2, 1, 0, 1);
    add(1, 4'b1111, 1, 4'b1000, 0, 0, 0,  4, 2, 2, 0, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0, 0,  4, 2, 3, 0, 1);
    add(1, 4'b1111, 1, 4'b0000, 1, 0, 0,  4, 2, 3, 0, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0, 1,  4, 2, 3, 1, 1);
    add(1, 4'b1111, 1, 4'b0000, 1, 1, 0,  6, 2, 3, 1, 1);
    add(1, 4'b1111, 1, 4'b0000, 1, 1, 0,  6, 2, 3, 0, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0,  1, 2, 3, 0, 0);

    reset_dut();
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #1;
      check($sformatf("tbl_state[%0d]", i), state, tbl[i].st);
      check($sformatf("tbl_ecode[%0d]", i), ecode, tbl[i].ec);
      check($sformatf("tbl_retry[%0d]", i), retry_cnt, tbl[i].rc);
      check($sformatf("tbl_crc_cnt[%0d]", i), crc_cnt, tbl[i].cc);
      check($sformatf("tbl_pd_req[%0d]", i), pd_req, tbl[i].pdreq);
      check($sformatf("tbl_rst_n[%0d]", i), rst_n, tbl[i].rstn);
      @(negedge clk);
    end

    // Lane 2 never ready: timeout, one retry, then fatal on the second.
    reset_dut();
    x = '0; x.rdone = 1; x.rdy = 4'b1011; drive(x);
    wait_state(2, 10, "enter_training");
    n = 0;
    while (state == 4'd2 && n < 100) begin
      n++; @(negedge clk); #1;
    end
    check("train_timeout_cycles", n, TT);
    check("timeout_retry_state", state, 8);
    check("timeout_ecode", ecode, 4);
    @(negedge clk); #1;
    check("retry_to_reset", state, 0);
    check("retry_cnt_one", retry_cnt, 1);
    check("rst_n_low_after_retry", rst_n, 0);
    wait_state(8, 60, "second_retry");
    @(negedge clk); #1;
    check("fatal_state", state, 5);
    check("fatal_ecode", ecode, 5);
    repeat (100) @(negedge clk);
    #1;
    check("fatal_hold_state", state, 5);
    check("fatal_hold_ecode", ecode, 5);

    // Fourth CRC cycle in LINK_READY hits the limit.
    reset_dut();
    x = '0; x.rdone = 1; x.rdy = '1; x.rrdy = 1; drive(x);
    wait_state(4, 20, "reach_link_ready");
    check("ready_retry_cnt", retry_cnt, 0);
    check("ready_ecode", ecode, 0);
    for (int k = 0; k < 4; k++) begin
      x.crc = '0; x.crc[k] = 1'b1; drive(x);
      @(negedge clk); #1;
      if (k < 3) check($sformatf("crc_hold_ready[%0d]", k), state, 4);
    end
    check("crc_limit_retry", state, 8);
    check("crc_limit_ecode", ecode, 3);
    check("crc_limit_cnt", crc_cnt, 4);
    x.crc = '0; drive(x);

    // Asynchronous reset in the middle of RX_LOCKED.
    reset_dut();
    x = '0; x.rdone = 1; x.rdy = '1; drive(x);
    wait_state(3, 20, "reach_rx_locked");
    x.crc = 4'b0010; drive(x);
    repeat (2) @(negedge clk);
    #1;
    check("locked_crc_state", state, 3);
    check("locked_crc_ecode", ecode, 2);
    check("locked_crc_cnt", crc_cnt, 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_crc_cnt", crc_cnt, 0);
    check("async_rst_ecode", ecode, 0);
    check("async_rst_rst_n", rst_n, 0);
    x = '0; drive(x);

    // Randomized run against the behavioural model.
    reset_dut();
    m = '{default: 0};
    for (int i = 0; i < 3000; i++) begin
      x = rand_in();
      drive(x);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        m = '{default: 0};
      end else begin
        rst = 1'b0;
      end
      #1;
      act = {state, ecode, 4'(retry_cnt), crc_cnt, pd_req, pd_ack, paccept, rst_n};
      exp = {4'(m.st), 4'(m.ec), 4'(m.rc), 8'(m.cc), m.pdreq, x.rpdreq, m.pacc, m.rstn};
      check($sformatf("rand_cycle[%0d]", i), act, exp);
      if (!rst) m = model_next(m, x);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qeciphy_lane_controller.md
QECIPHY_LANE_CONTROLLER -- requirements
Module: qeciphy_lane_controller

Interface
REQ-001 Parameter NUM_LANES, default 4, number of RX lanes (1..16).
REQ-002 Parameter TRAIN_TIMEOUT, default 65535, cycles allowed in LINK_TRAINING+RX_LOCKED before retry (>=2).
REQ-003 Parameter MAX_RETRIES, default 3, link retrain attempts before FAULT_FATAL (>=0).
REQ-004 Parameter CRC_ERR_LIMIT, default 8, CRC-error cycles tolerated in LINK_READY before retry (1..255).
REQ-005 axis_clk  in  1  sole clock.
REQ-006 axis_rst  in  1  asynchronous, active-high reset.
REQ-007 i_reset_done  in  1  TX/RX transceiver reset complete.
REQ-008 i_rx_rdy  in  NUM_LANES  per-lane RX aligned.
REQ-009 i_remote_rx_rdy  in  1  far end reports RX ready.
REQ-010 i_fap_missing / i_crc_error  in  NUM_LANES each  per-lane error strobes.
REQ-011 i_preq, i_pstate  in  1 each  power request; pstate 1=up, 0=down.
REQ-012 o_paccept  out  1  power request accepted.
REQ-013 i_remote_pd_req, i_remote_pd_ack  in  1 each  far-end powerdown handshake.
REQ-014 o_pd_req, o_pd_ack  out  1 each  local powerdown handshake.
REQ-015 o_state  out  4  FSM state encoding; o_ecode  out  4  error code.
REQ-016 o_retry_cnt  out  $clog2(MAX_RETRIES+1) (min 1)  retries consumed; o_crc_err_cnt  out  8  saturating CRC-error cycle count.
REQ-017 o_rst_n  out  1  registered active-low datapath reset.

Function
REQ-018 States: RESET=0, WAIT_FOR_RESET=1, LINK_TRAINING=2, RX_LOCKED=3, LINK_READY=4, FAULT_FATAL=5, SLEEP=6, WAIT_FOR_POWERDOWN=7, RETRY=8.
REQ-019 any_fap = OR of i_fap_missing; any_crc = OR of i_crc_error; all_rdy = AND of i_rx_rdy.
REQ-020 RESET -> WAIT_FOR_RESET unconditionally; WAIT_FOR_RESET -> LINK_TRAINING when i_reset_done.
REQ-021 LINK_TRAINING: all_rdy -> RX_LOCKED; else timer==TRAIN_TIMEOUT-1 -> RETRY (cause TRAIN_TIMEOUT).
REQ-022 Training timer clears on entering LINK_TRAINING, counts in LINK_TRAINING and RX_LOCKED, does not reset on RX_LOCKED entry.
REQ-023 RX_LOCKED priority: any_fap -> RETRY (FAP_MISSING); timer==TRAIN_TIMEOUT-1 -> RETRY (TRAIN_TIMEOUT); i_remote_rx_rdy -> LINK_READY.
REQ-024 LINK_READY priority: any_fap -> RETRY (FAP_MISSING); any_crc with o_crc_err_cnt==CRC_ERR_LIMIT-1 -> RETRY (CRC_LIMIT); i_remote_pd_ack -> SLEEP; o_pd_ack -> WAIT_FOR_POWERDOWN.
REQ-025 RETRY: o_retry_cnt==MAX_RETRIES -> FAULT_FATAL, ecode RETRY_EXHAUSTED; else o_retry_cnt+1, -> RESET; one cycle in RETRY.
REQ-026 SLEEP -> WAIT_FOR_RESET when pu_req; pu_req clears o_retry_cnt.
REQ-027 WAIT_FOR_POWERDOWN -> RESET when any_fap; FAULT_FATAL holds until axis_rst.
REQ-028 o_crc_err_cnt +1 per cycle with any_crc in RX_LOCKED or LINK_READY (independent of lanes asserting), saturates at 255, clears on entering LINK_TRAINING.
REQ-029 Error codes: OK=0, FAP_MISSING=1, CRC_ERROR=2, CRC_LIMIT=3, TRAIN_TIMEOUT=4, RETRY_EXHAUSTED=5.
REQ-030 o_ecode updates: CRC_ERROR on any_crc below limit in RX_LOCKED/LINK_READY; retry cause on RETRY entry; FAP_MISSING beats CRC when simultaneous; persists through retries until axis_rst.
REQ-031 o_pd_req sets in LINK_READY with i_preq & ~i_pstate, clears in SLEEP, else holds.
REQ-032 pu_req registered = SLEEP & i_preq & i_pstate.
REQ-033 o_paccept: clear if ~i_preq & o_paccept; else set in SLEEP with i_preq & ~i_pstate or LINK_READY with i_preq & i_pstate; else hold.
REQ-034 o_pd_ack = i_remote_pd_req combinationally; o_state = state combinationally.
REQ-035 o_rst_n registered, low the cycle after state is RESET, RETRY, SLEEP or FAULT_FATAL.

Reset
REQ-036 axis_rst asynchronously forces state RESET, all counters 0, o_ecode OK, o_pd_req, pu_req, o_paccept, o_rst_n 0; mid-operation assertion aborts any handshake.

Structure
REQ-037 qeciphy_pkg holds fsm_t and error_t enums and encodings.
REQ-038 One sub-module qeciphy_sat_counter (parametrised width, clear, enable, saturate) instanced for timer and CRC count.

Verification
REQ-039 NUM_LANES=4, lanes ready one at a time, remote ready -> LINK_READY, o_retry_cnt=0, o_ecode=OK.
REQ-040 TRAIN_TIMEOUT=16, lane 2 never ready -> RETRY at 16th training cycle, ecode 4, o_retry_cnt=1, o_rst_n low next cycle.
REQ-041 MAX_RETRIES=1, persistent timeout -> second RETRY goes FAULT_FATAL, ecode 5, stays after 100 cycles.
REQ-042 CRC_ERR_LIMIT=4, four any_crc cycles in LINK_READY -> RETRY on fourth, ecode 3; three cycles keep LINK_READY, ecode 2.
REQ-043 LINK_READY, i_preq=1 i_pstate=0 -> o_pd_req=1; remote_pd_ack -> SLEEP, o_pd_req=0; i_preq=1 i_pstate=1 -> WAIT_FOR_RESET two cycles later, o_retry_cnt=0.
REQ-044 axis_rst asserted mid-RX_LOCKED -> immediately RESET, o_crc_err_cnt=0, o_ecode=OK.
